// File: rtl/imem_if.sv
// imem_if: bundles the loader's handshake, field, control and read-port
// signals. clk/rst stay plain ports on the loader.
//   slave  modport : used by imem_loader (drives in_ready, rd_data, start,
//                    count, err, rd_perr)
//   master modport : used by the producer / fetch side
interface imem_if #(parameter int AW = 6);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [11:0]   imm;
  logic          last;
  logic          reload;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          start;
  logic [AW:0]   count;
  logic          err;
  logic          rd_perr;

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, imm, last, reload, rd_addr,
    output in_ready, rd_data, start, count, err, rd_perr
  );

  modport master (
    output in_valid, opcode, rs1, rs2, rd, imm, last, reload, rd_addr,
    input  in_ready, rd_data, start, count, err, rd_perr
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: encodes decoded instruction fields into 32-bit words, writes
// them sequentially into an internal instruction memory, pads the remainder
// with NOP (all-zero) and then raises start for the fetch stage.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : imem_if.slave - in_valid/in_ready handshake, opcode/rs1/rs2/
//               rd/imm/last fields, reload, rd_addr/rd_data combinational read
//               port, start, count, err pulse, rd_perr
// Optional: define IMEM_PARITY_EN to put even parity in ins[31] and flag
//   parity errors on rd_perr; otherwise ins[31]=0 and rd_perr=0.
module imem_loader #(
  parameter int MEM_DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  imem_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {LOAD, PAD, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          start_q, start_d;
  logic          err_q, err_d;

  logic [31:0]   mem [MEM_DEPTH];
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   enc;
  logic          accept;
  logic          at_end;

  // Field packing; rs2 and imm share the bits above rd.
  always_comb begin
    enc       = '0;
    enc[2:0]  = bus.opcode;
    enc[7:3]  = bus.rs1;
    enc[12:8] = bus.rd;
    if (bus.opcode == 3'b011) enc[24:13] = bus.imm;
    else                      enc[17:13] = bus.rs2;
`ifdef IMEM_PARITY_EN
    enc[31] = ^enc[30:0];
`endif
  end

  assign accept = bus.in_valid & bus.in_ready;
  // MEM_DEPTH is a power of two, so the last entry is all ones.
  assign at_end = &wr_ptr_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = 1'b0;
    we       = 1'b0;
    wdata    = enc;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (bus.opcode[2]) begin
            // Illegal word is dropped but still terminates the program.
            err_d = 1'b1;
            if (bus.last) state_d = PAD;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            if (at_end)        state_d = RUN;
            else if (bus.last) state_d = PAD;
          end
        end
      end
      PAD: begin
        we       = 1'b1;
        wdata    = '0;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (at_end) state_d = RUN;
      end
      RUN: begin
        if (bus.reload) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    start_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      count_q  <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  // Storage is intentionally not reset; we is low while rst holds LOAD with
  // in_ready deasserted.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wdata;
  end

  assign bus.in_ready = (state_q == LOAD) & ~rst;
  assign bus.start    = start_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
  assign bus.rd_data  = mem[bus.rd_addr];
`ifdef IMEM_PARITY_EN
  assign bus.rd_perr  = ^bus.rd_data;
`else
  assign bus.rd_perr  = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed vectors, hand-written corner
// sequences and a randomized phase, all checked against a behavioural model.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_if #(.AW(AW)) bus();
  imem_loader #(.MEM_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0=loading, 1=padding, 2=running.
  int          m_phase, m_ptr, m_count;
  bit          m_err;
  bit          m_known [DEPTH];
  logic [31:0] m_mem   [DEPTH];

  function automatic logic [31:0] par(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef IMEM_PARITY_EN
    if (^w) r = w | 32'h8000_0000;
`endif
    return r;
  endfunction

  // Word built by arithmetic on field positions.
  function automatic logic [31:0] ref_word(input int op, input int a,
                                           input int b, input int d,
                                           input int im);
    int hi;
    hi = (op == 3) ? im : b;
    return par(32'(op + a * 8 + d * 256 + hi * 8192));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_count = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int op;
    m_err = 1'b0;
    op = int'(bus.opcode);
    if (m_phase == 0) begin
      if (bus.in_valid) begin
        if (op >= 4) begin
          m_err = 1'b1;
          if (bus.last) m_phase = 1;
        end else begin
          m_mem[m_ptr]   = ref_word(op, int'(bus.rs1), int'(bus.rs2),
                                    int'(bus.rd), int'(bus.imm));
          m_known[m_ptr] = 1'b1;
          m_count++;
          if (m_ptr == DEPTH - 1) m_phase = 2;
          else if (bus.last)      m_phase = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
    end else if (m_phase == 1) begin
      m_mem[m_ptr]   = 32'h0;
      m_known[m_ptr] = 1'b1;
      if (m_ptr == DEPTH - 1) m_phase = 2;
      m_ptr = (m_ptr + 1) % DEPTH;
    end else if (bus.reload) begin
      m_phase = 0; m_ptr = 0; m_count = 0;
    end
  endtask

  // One clock: update model from the inputs present at the edge, then
  // sample all outputs 2 time units later.
  task automatic tick(input int raddr);
    int a;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    a = (raddr < 0) ? int'($urandom_range(0, DEPTH - 1)) : raddr;
    bus.rd_addr = AW'(a);
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0 && !rst));
    chk("start",    32'(bus.start),    32'(m_phase == 2));
    chk("count",    32'(bus.count),    32'(m_count));
    chk("err",      32'(bus.err),      32'(m_err));
    if (m_known[a]) begin
      chk("rd_data", bus.rd_data, m_mem[a]);
      chk("rd_perr", 32'(bus.rd_perr), 32'h0);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.last = 1'b0; bus.reload = 1'b0;
  endtask

  task automatic put(input logic [2:0] op, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] d,
                     input logic [11:0] im, input logic lst);
    bus.in_valid = 1'b1; bus.opcode = op; bus.rs1 = a; bus.rs2 = b;
    bus.rd = d; bus.imm = im; bus.last = lst;
  endtask

  task automatic put_rand_legal(input logic lst);
    put(3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
        12'($urandom), lst);
  endtask

  // Bounded wait for RUN; returns number of cycles spent.
  task automatic wait_run(output int n);
    n = 0;
    while (m_phase != 2 && n < 200) begin
      tick(-1);
      n++;
    end
    chk("wait_run_start", 32'(bus.start), 32'h1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic        last;
    logic [31:0] exp_word;
    int          exp_addr;
    int          exp_count;
    logic        exp_err;
  } vec_t;

  vec_t tbl [5];
  int   n;

  initial begin
    tbl[0] = '{3'b001, 5'd1, 5'd3, 5'd2,  12'h000, 1'b0, 32'h0000_6209,  0, 1, 1'b0};
    tbl[1] = '{3'b011, 5'd4, 5'd7, 5'd5,  12'hFFF, 1'b0, 32'h01FF_E523,  1, 2, 1'b0};
    tbl[2] = '{3'b101, 5'd9, 5'd9, 5'd9,  12'h123, 1'b0, 32'h0000_0000, -1, 2, 1'b1};
    tbl[3] = '{3'b010, 5'd6, 5'd8, 5'd10, 12'h000, 1'b0, 32'h0001_0A32,  2, 3, 1'b0};
    tbl[4] = '{3'b000, 5'd31,5'd0, 5'd1,  12'h000, 1'b1, 32'h0000_01F8,  3, 4, 1'b0};

    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 1'b0; m_mem[i] = '0; end
    model_reset();
    idle();
    put(3'b000, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
    bus.in_valid = 1'b0;
    bus.rd_addr  = '0;

    tick(-1);
    tick(-1);
    chk("reset_count", 32'(bus.count), 32'h0);
    chk("reset_start", 32'(bus.start), 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'h1);

    // Directed vectors: ADD, ADDI (rs2 ignored), illegal, MULT, NOP last.
    for (int i = 0; i < 5; i++) begin
      put(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].last);
      tick(tbl[i].exp_addr < 0 ? 0 : tbl[i].exp_addr);
      if (tbl[i].exp_addr >= 0)
        chk("tbl_word", bus.rd_data, par(tbl[i].exp_word));
      chk("tbl_count", 32'(bus.count), 32'(tbl[i].exp_count));
      chk("tbl_err",   32'(bus.err),   32'(tbl[i].exp_err));
    end
    idle();
    chk("pad_in_ready", 32'(bus.in_ready), 32'h0);
    wait_run(n);
    chk("pad_cycles", 32'(n), 32'd60);
    chk("run_count",  32'(bus.count), 32'd4);
    tick(10);
    chk("pad_word10", bus.rd_data, 32'h0);

    // Reload from RUN, then 64 legal words with last=0 go straight to RUN.
    bus.reload = 1'b1;
    tick(-1);
    bus.reload = 1'b0;
    chk("reload_start", 32'(bus.start),    32'h0);
    chk("reload_ready", 32'(bus.in_ready), 32'h1);
    chk("reload_count", 32'(bus.count),    32'h0);
    put(3'b001, 5'd17, 5'd18, 5'd19, 12'h0, 1'b0);
    tick(0);
    chk("reload_addr0", bus.rd_data, ref_word(1, 17, 18, 19, 0));
    for (int i = 1; i < DEPTH; i++) begin
      put_rand_legal(1'b0);
      tick(-1);
    end
    idle();
    chk("full_start", 32'(bus.start),    32'h1);
    chk("full_count", 32'(bus.count),    32'd64);
    chk("full_ready", 32'(bus.in_ready), 32'h0);
    tick(-1);

    // Reset in the middle of PAD.
    bus.reload = 1'b1;
    tick(-1);
    bus.reload = 1'b0;
    put_rand_legal(1'b0); tick(-1);
    put_rand_legal(1'b1); tick(-1);
    idle();
    for (int i = 0; i < 5; i++) tick(-1);
    #1;
    rst = 1'b1;
    #1;
    chk("midpad_start", 32'(bus.start), 32'h0);
    chk("midpad_count", 32'(bus.count), 32'h0);
    model_reset();
    tick(-1);
    rst = 1'b0;
    put(3'b011, 5'd2, 5'd0, 5'd3, 12'h7FF, 1'b1);
    tick(0);
    chk("after_rst_addr0", bus.rd_data, ref_word(3, 2, 0, 3, 12'h7FF));
    idle();
    wait_run(n);
    chk("after_rst_count", 32'(bus.count), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.opcode   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                 : 3'($urandom_range(0, 3));
      bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom); bus.rd = 5'($urandom);
      bus.imm = 12'($urandom);
      bus.last   = ($urandom_range(0, 19) == 0);
      bus.reload = ($urandom_range(0, 7) == 0);
      tick(-1);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction fetch stage and predecoder.
- Accepts decoded instruction fields over a valid/ready handshake and encodes them into the 32-bit instruction format.
- Writes the encoded words sequentially into an internal instruction memory, then pads the unused entries with NOP.
- Asserts start so the fetch stage can begin reading through a combinational read port.

Parameters:
- MEM_DEPTH, 64, number of 32-bit instruction entries (power of two, >=4).
- AW, $clog2(MEM_DEPTH), address width (localparam).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader can accept a word this cycle.
- opcode  input  3  000 NOP, 001 ADD, 010 MULT, 011 ADDI; 1xx illegal.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2 (ignored for ADDI).
- rd  input  5  destination register.
- imm  input  12  signed immediate (used only for ADDI).
- last  input  1  qualifies the accepted word as the final program word.
- reload  input  1  synchronous request to restart loading (honoured only in RUN).
- rd_addr  input  AW  fetch read address.
- rd_data  output  32  mem[rd_addr], combinational.
- start  output  1  program loaded; fetch may run.
- count  output  AW+1  legal program words written, excluding pad.
- err  output  1  one-cycle pulse on an illegal opcode.
- rd_perr  output  1  parity error on rd_data (PARITY_EN only).

Behaviour:
- Encoding:
  - ins[2:0]=opcode, ins[7:3]=rs1, ins[12:8]=rd.
  - ADDI: ins[24:13]=imm.
  - All other opcodes: ins[17:13]=rs2, ins[24:18]=0.
  - ins[31:25]=0.
- States: LOAD, PAD, RUN. Reset enters LOAD.
- Reset (asynchronous): state=LOAD, wr_ptr=0, count=0, start=0, err=0. in_ready goes to 1 once reset deasserts. Memory contents are not reset.
- Accept condition: in_valid && in_ready.
- LOAD:
  - in_ready=1, start=0.
  - Legal accept: mem[wr_ptr]<=encoded word; wr_ptr++; count++.
  - Illegal accept (opcode[2]=1): nothing written; wr_ptr and count unchanged; err=1 for the following cycle.
  - An accept with last=1 goes to PAD. This applies even if the word is illegal.
  - A legal accept written to address MEM_DEPTH-1 goes directly to RUN, regardless of last.
- PAD:
  - in_ready=0.
  - Each cycle, mem[wr_ptr]<=0 (NOP) and wr_ptr++.
  - After writing address MEM_DEPTH-1, go to RUN.
  - count does not change.
- RUN:
  - start=1 (registered, held), in_ready=0.
  - reload=1 returns to LOAD with wr_ptr=0, count=0, start=0 on the next edge.
- reload in LOAD or PAD is ignored. in_valid while in_ready=0 is ignored.
- Read port:
  - Combinational; a word written at edge N is visible on rd_data after edge N.
  - Reading the address being written returns the old contents until the edge.
- Reset asserted mid-LOAD or mid-PAD aborts immediately: start=0, and the next load starts at address 0.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - ins[31] = XOR of ins[30:0], giving even parity over the full word.
  - rd_perr = XOR of rd_data[31:0]; nonzero means a parity error.
  - PAD words stay 0, which is valid parity.
- Undefined: ins[31]=0 and rd_perr tied to 0.

Test Plan:
- Reset, then ADD with rs1=1, rd=2, rs2=3 -> rd_addr=0 reads 0x00006209; count=1; err=0. With IMEM_PARITY_EN, reads 0x80006209.
- ADDI with rs1=4, rd=5, imm=12'hFFF, rs2=7 -> word 0x01FFE523 at the next address; rs2 is ignored.
- Three legal words, the third with last=1 (MEMDEPTH 64) -> in_ready=0, 61 PAD cycles, then start=1; count=3; rd_addr=10 reads 0.
- Illegal opcode 3'b101 between two ADDs -> err high exactly one cycle; count unchanged; the second ADD lands at the address the illegal word would have used.
- 64 legal words with last=0 -> after the 64th accept, go straight to RUN (no PAD); start=1; count=64; in_ready=0.
- Reset asserted mid-PAD -> start=0 and count=0 immediately. A new single-word load with last=1 reaches RUN with count=1.
- In RUN, pulse reload -> next cycle start=0, in_ready=1, count=0; the next word is written to address 0.
